unit_switch_requester: RTL and testbench
========================================

# unit_switch_requester

Requesting side of the CPU/FPU hand-off interrupt protocol. Watches the currently active sequencer, raises `cpu_int` when the CPU fetches a floating-point instruction and `fpu_int` when the FPU finishes, and captures the exception PC. It then stalls until the interrupt handler's `cpu_seq_en`/`fpu_seq_en` levels confirm the switch, retrying or flagging an error if no confirmation arrives. Sits between both sequencers and the interrupt handler.

## Interface

- `OPW`, 6: opcode width.
- `FP_OPCODE`, 6'b010001: opcode that triggers the CPU-to-FPU hand-off.
- `PULSE_LEN`, 2: cycles each interrupt request is held high (min 1).
- `TIMEOUT`, 16: cycles to wait for acknowledge after a pulse (min 2).
- `MAX_RETRY`, 3: re-pulses before error.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_instr_valid`  in  1  CPU has a decoded instruction this cycle.
- `cpu_opcode`  in  OPW  opcode of that instruction.
- `cpu_pc`  in  32  PC of that instruction.
- `fpu_done`  in  1  FPU finished its routine (single-cycle strobe).
- `fpu_pc`  in  32  FPU PC at `fpu_done`.
- `cpu_seq_en`, `fpu_seq_en`  in  1  enable levels driven by the interrupt handler.
- `cpu_int`  out  1  request CPU-to-FPU switch (registered pulse).
- `fpu_int`  out  1  request FPU-to-CPU switch (registered pulse).
- `stall`  out  1  freezes both sequencers while a switch is pending.
- `epc`  out  32  PC captured at the triggering event.
- `owner`  out  1  0 = CPU active, 1 = FPU active.
- `err`  out  1  sticky: switch not acknowledged after all retries.

## Operation

- States: CPU_RUN, FPU_RUN, REQ, WAIT, ERR. An internal `dir` bit holds the switch direction (0 = to FPU, 1 = to CPU).
- CPU_RUN: if `cpu_instr_valid && cpu_opcode == FP_OPCODE`, latch `epc <= cpu_pc`, set `dir = 0`, clear the retry count, go to REQ. `fpu_done` is ignored.
- FPU_RUN: if `fpu_done`, latch `epc <= fpu_pc`, set `dir = 1`, clear the retry count, go to REQ. CPU triggers are ignored.
- REQ: drive `cpu_int` (`dir = 0`) or `fpu_int` (`dir = 1`) high for exactly PULSE_LEN cycles, then go to WAIT. Only one of the two is ever high.
- WAIT: both interrupts low. The timeout counter starts at 0 and increments each cycle.
  - Acknowledge for `dir = 0`: `fpu_seq_en && !cpu_seq_en`. Go to FPU_RUN, `owner = 1`.
  - Acknowledge for `dir = 1`: `cpu_seq_en && !fpu_seq_en`. Go to CPU_RUN, `owner = 0`.
  - Counter reaches TIMEOUT-1 without acknowledge: if retries < MAX_RETRY, increment retries and go to REQ; otherwise go to ERR.
- ERR: `err = 1`, `stall = 1`, no pulses. Left only by `reset`.
- `stall = 1` in REQ, WAIT and ERR; 0 in CPU_RUN and FPU_RUN.
- `epc` changes only at trigger capture; it holds through retries and ERR.
- `owner` changes only on acknowledge.

## Timing

- Reset (asynchronous, any state, including mid-pulse): state CPU_RUN; `cpu_int = fpu_int = stall = owner = err = 0`; `epc = 0`; counters cleared.
- Trigger sampled at edge N: `stall`, the interrupt line and `epc` are all valid after edge N (one-cycle latency).
- Interrupt pulse: high for cycles N+1 through N+PULSE_LEN, then at least 1 cycle low before any retry. This guarantees a fresh rising edge for the edge-triggered handler.
- An acknowledge sampled in WAIT at edge M gives `owner` updated and `stall = 0` after M.
- Acknowledge levels already true during REQ are only acted on in WAIT, so the earliest return is 1 cycle after the pulse ends.
- Worst case to ERR: (MAX_RETRY+1)·(PULSE_LEN+TIMEOUT) cycles after the trigger.

## Test plan

- Reset, then CPU trigger (opcode 6'b010001, pc 0x40). Handler answers `fpu_seq_en = 1`, `cpu_seq_en = 0` in WAIT cycle 3. Required: `cpu_int` high 2 cycles, `epc = 0x40`, `owner = 1`, `stall = 0` one cycle later.
- In FPU_RUN, `fpu_done` with `fpu_pc = 0x88`, then acknowledge. Required: `fpu_int` pulse only, `epc = 0x88`, `owner = 0`.
- CPU trigger with no acknowledge ever. Required: 4 pulses, each 2 cycles high, spaced 18 cycles apart; `err = 1` after 72 cycles; `stall` stays high.
- Non-FP opcode with valid high in CPU_RUN, and `fpu_done` in CPU_RUN. Required: no pulse, `stall = 0`, `epc` unchanged.
- Reset asserted during the second cycle of a `cpu_int` pulse. Required: all outputs 0 asynchronously; next trigger behaves as a fresh request.
- Acknowledge levels held true throughout REQ. Required: switch completes in the first WAIT cycle, not earlier.

Source files
------------

// File: rtl/unit_switch_requester_if.sv
// Hand-off bus between the switch requester, both sequencers and the interrupt handler.
// The master modport is the requester; the slave modport is everything around it.
interface unit_switch_requester_if #(
   parameter int OPW = 6
);
   logic           cpu_instr_valid;
   logic [OPW-1:0] cpu_opcode;
   logic [31:0]    cpu_pc;
   logic           fpu_done;
   logic [31:0]    fpu_pc;
   logic           cpu_seq_en;
   logic           fpu_seq_en;
   logic           cpu_int;
   logic           fpu_int;
   logic           stall;
   logic [31:0]    epc;
   logic           owner;
   logic           err;

   modport master (
      input  cpu_instr_valid, cpu_opcode, cpu_pc, fpu_done, fpu_pc,
             cpu_seq_en, fpu_seq_en,
      output cpu_int, fpu_int, stall, epc, owner, err
   );

   modport slave (
      output cpu_instr_valid, cpu_opcode, cpu_pc, fpu_done, fpu_pc,
             cpu_seq_en, fpu_seq_en,
      input  cpu_int, fpu_int, stall, epc, owner, err
   );
endinterface

// File: rtl/unit_switch_requester.sv
// Requesting side of the CPU/FPU hand-off: pulses cpu_int/fpu_int, captures the
// exception PC, stalls until the handler's enable levels confirm, retries, then errors.
module unit_switch_requester #(
   parameter int             OPW       = 6,
   parameter logic [OPW-1:0] FP_OPCODE = OPW'(6'b010001),
   parameter int             PULSE_LEN = 2,   // min 1
   parameter int             TIMEOUT   = 16,  // min 2
   parameter int             MAX_RETRY = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   unit_switch_requester_if.master  bus
);

   localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT);
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LEN - 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

   typedef enum logic [2:0] {
      CPU_RUN,
      FPU_RUN,
      REQ,
      WAIT,
      ERR
   } state_t;

   state_t          state_q, state_d;
   logic            dir_q, dir_d;        // 0 = switching to FPU, 1 = switching to CPU
   logic [31:0]     epc_q, epc_d;
   logic            owner_q, owner_d;
   logic [PW-1:0]   pulse_cnt_q, pulse_cnt_d;
   logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic [RW-1:0]   retry_cnt_q, retry_cnt_d;

   logic            cpu_int_q, cpu_int_d;
   logic            fpu_int_q, fpu_int_d;
   logic            stall_q, stall_d;
   logic            err_q, err_d;

   logic            cpu_trigger;
   logic            ack;

   assign cpu_trigger = bus.cpu_instr_valid && (bus.cpu_opcode == FP_OPCODE);
   assign ack = dir_q ? (bus.cpu_seq_en && !bus.fpu_seq_en)
                      : (bus.fpu_seq_en && !bus.cpu_seq_en);

   // State register; the interrupt lines are registered from the next-state view so
   // they come straight off flops and line up with the state they belong to.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= CPU_RUN;
         dir_q       <= 1'b0;
         epc_q       <= '0;
         owner_q     <= 1'b0;
         pulse_cnt_q <= '0;
         tmo_cnt_q   <= '0;
         retry_cnt_q <= '0;
         cpu_int_q   <= 1'b0;
         fpu_int_q   <= 1'b0;
         stall_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         epc_q       <= epc_d;
         owner_q     <= owner_d;
         pulse_cnt_q <= pulse_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         retry_cnt_q <= retry_cnt_d;
         cpu_int_q   <= cpu_int_d;
         fpu_int_q   <= fpu_int_d;
         stall_q     <= stall_d;
         err_q       <= err_d;
      end
   end

   // NOTE: every variable gets a hold default before the case so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      dir_d       = dir_q;
      epc_d       = epc_q;
      owner_d     = owner_q;
      pulse_cnt_d = pulse_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      retry_cnt_d = retry_cnt_q;

      unique case (state_q)
         CPU_RUN: begin
            if (cpu_trigger) begin
               state_d     = REQ;
               dir_d       = 1'b0;
               epc_d       = bus.cpu_pc;
               retry_cnt_d = '0;
               pulse_cnt_d = '0;
            end
         end
         FPU_RUN: begin
            if (bus.fpu_done) begin
               state_d     = REQ;
               dir_d       = 1'b1;
               epc_d       = bus.fpu_pc;
               retry_cnt_d = '0;
               pulse_cnt_d = '0;
            end
         end
         REQ: begin
            if (pulse_cnt_q == PULSE_LAST) begin
               state_d   = WAIT;
               tmo_cnt_d = '0;
            end else begin
               pulse_cnt_d = pulse_cnt_q + PW'(1);
            end
         end
         WAIT: begin
            // Acknowledge wins over a timeout landing on the same cycle.
            if (ack) begin
               state_d = dir_q ? CPU_RUN : FPU_RUN;
               owner_d = !dir_q;
            end else if (tmo_cnt_q == TMO_LAST) begin
               if (retry_cnt_q < RETRY_MAX) begin
                  state_d     = REQ;
                  retry_cnt_d = retry_cnt_q + RW'(1);
                  pulse_cnt_d = '0;
               end else begin
                  state_d = ERR;
               end
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
         end
         ERR: begin
            state_d = ERR;
         end
         default: begin
            state_d = CPU_RUN;
         end
      endcase
   end

   always_comb begin
      cpu_int_d = (state_d == REQ) && !dir_d;
      fpu_int_d = (state_d == REQ) &&  dir_d;
      stall_d   = (state_d == REQ) || (state_d == WAIT) || (state_d == ERR);
      err_d     = (state_d == ERR);
   end

   assign bus.cpu_int = cpu_int_q;
   assign bus.fpu_int = fpu_int_q;
   assign bus.stall   = stall_q;
   assign bus.epc     = epc_q;
   assign bus.owner   = owner_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_unit_switch_requester.sv
// Directed bench for unit_switch_requester: hand-off in both directions, ignored
// triggers, retry/timeout to error, asynchronous reset mid-pulse and early acknowledge.
module tb_unit_switch_requester;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   unit_switch_requester_if #(.OPW(6)) bus ();

   unit_switch_requester #(
      .OPW       (6),
      .FP_OPCODE (6'b010001),
      .PULSE_LEN (2),
      .TIMEOUT   (16),
      .MAX_RETRY (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Observed outputs packed as {cpu_int, fpu_int, stall, owner, err}.
   logic [4:0] obs;
   assign obs = {bus.cpu_int, bus.fpu_int, bus.stall, bus.owner, bus.err};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_trigger(input logic [5:0] op, input logic [31:0] pc);
      bus.cpu_instr_valid = 1'b1;
      bus.cpu_opcode      = op;
      bus.cpu_pc          = pc;
      tick();
      bus.cpu_instr_valid = 1'b0;
   endtask

   task automatic fpu_trigger(input logic [31:0] pc);
      bus.fpu_done = 1'b1;
      bus.fpu_pc   = pc;
      tick();
      bus.fpu_done = 1'b0;
   endtask

   task automatic test_reset();
      reset               = 1'b1;
      bus.cpu_instr_valid = 1'b0;
      bus.cpu_opcode      = '0;
      bus.cpu_pc          = '0;
      bus.fpu_done        = 1'b0;
      bus.fpu_pc          = '0;
      bus.cpu_seq_en      = 1'b1;
      bus.fpu_seq_en      = 1'b0;
      repeat (2) tick();
      checks++;
      if (obs !== 5'b00000) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected %b", obs, 5'b00000);
      end
      checks++;
      if (bus.epc !== 32'h0) begin
         errors++;
         $display("FAIL reset_epc: got %h expected %h", bus.epc, 32'h0);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (obs !== 5'b00000) begin
         errors++;
         $display("FAIL reset_idle: got %b expected %b", obs, 5'b00000);
      end
   endtask

   task automatic test_cpu_to_fpu();
      cpu_trigger(6'b010001, 32'h40);
      checks++;
      if (obs !== 5'b10100 || bus.epc !== 32'h40) begin
         errors++;
         $display("FAIL c2f_pulse1: got %b epc %h expected %b epc %h", obs, bus.epc, 5'b10100, 32'h40);
      end
      tick();
      checks++;
      if (obs !== 5'b10100) begin
         errors++;
         $display("FAIL c2f_pulse2: got %b expected %b", obs, 5'b10100);
      end
      tick();  // WAIT cycle 1
      checks++;
      if (obs !== 5'b00100) begin
         errors++;
         $display("FAIL c2f_wait1: got %b expected %b", obs, 5'b00100);
      end
      tick();  // WAIT cycle 2
      tick();  // WAIT cycle 3: handler answers now
      checks++;
      if (obs !== 5'b00100) begin
         errors++;
         $display("FAIL c2f_wait3: got %b expected %b", obs, 5'b00100);
      end
      bus.fpu_seq_en = 1'b1;
      bus.cpu_seq_en = 1'b0;
      tick();
      checks++;
      if (obs !== 5'b00010 || bus.epc !== 32'h40) begin
         errors++;
         $display("FAIL c2f_ack: got %b epc %h expected %b epc %h", obs, bus.epc, 5'b00010, 32'h40);
      end
   endtask

   task automatic test_fpu_to_cpu();
      // A CPU FP opcode while the FPU owns execution must be ignored.
      cpu_trigger(6'b010001, 32'h77);
      checks++;
      if (obs !== 5'b00010 || bus.epc !== 32'h40) begin
         errors++;
         $display("FAIL f2c_cpu_ignored: got %b epc %h expected %b epc %h", obs, bus.epc, 5'b00010, 32'h40);
      end
      fpu_trigger(32'h88);
      checks++;
      if (obs !== 5'b01110 || bus.epc !== 32'h88) begin
         errors++;
         $display("FAIL f2c_pulse1: got %b epc %h expected %b epc %h", obs, bus.epc, 5'b01110, 32'h88);
      end
      tick();
      checks++;
      if (obs !== 5'b01110) begin
         errors++;
         $display("FAIL f2c_pulse2: got %b expected %b", obs, 5'b01110);
      end
      tick();
      checks++;
      if (obs !== 5'b00110) begin
         errors++;
         $display("FAIL f2c_wait1: got %b expected %b", obs, 5'b00110);
      end
      bus.cpu_seq_en = 1'b1;
      bus.fpu_seq_en = 1'b0;
      tick();
      checks++;
      if (obs !== 5'b00000 || bus.epc !== 32'h88) begin
         errors++;
         $display("FAIL f2c_ack: got %b epc %h expected %b epc %h", obs, bus.epc, 5'b00000, 32'h88);
      end
   endtask

   task automatic test_ignored_triggers();
      cpu_trigger(6'b000000, 32'h1234);
      checks++;
      if (obs !== 5'b00000 || bus.epc !== 32'h88) begin
         errors++;
         $display("FAIL ign_nonfp: got %b epc %h expected %b epc %h", obs, bus.epc, 5'b00000, 32'h88);
      end
      fpu_trigger(32'h99);
      checks++;
      if (obs !== 5'b00000 || bus.epc !== 32'h88) begin
         errors++;
         $display("FAIL ign_fpu_done: got %b epc %h expected %b epc %h", obs, bus.epc, 5'b00000, 32'h88);
      end
      tick();
      checks++;
      if (obs !== 5'b00000) begin
         errors++;
         $display("FAIL ign_settle: got %b expected %b", obs, 5'b00000);
      end
   endtask

   task automatic test_timeout_err();
      logic [4:0] exp;
      logic       exp_int;
      logic       prev;
      int         pulses;
      prev   = 1'b0;
      pulses = 0;
      // Enables stay at CPU-active levels, which never acknowledge a switch to the FPU.
      cpu_trigger(6'b010001, 32'h200);
      for (int t = 0; t < 76; t++) begin
         exp_int = (t < 72) && ((t % 18) < 2);
         exp     = {exp_int, 1'b0, 1'b1, 1'b0, (t >= 72)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL timeout_t%0d: got %b expected %b", t, obs, exp);
         end
         if (bus.cpu_int && !prev) pulses++;
         prev = bus.cpu_int;
         tick();
      end
      checks++;
      if (pulses != 4) begin
         errors++;
         $display("FAIL timeout_pulses: got %0d expected %0d", pulses, 4);
      end
      checks++;
      if (bus.epc !== 32'h200) begin
         errors++;
         $display("FAIL timeout_epc: got %h expected %h", bus.epc, 32'h200);
      end
      // A late acknowledge must not release the error state.
      bus.fpu_seq_en = 1'b1;
      bus.cpu_seq_en = 1'b0;
      repeat (3) tick();
      checks++;
      if (obs !== 5'b00101) begin
         errors++;
         $display("FAIL err_sticky: got %b expected %b", obs, 5'b00101);
      end
   endtask

   task automatic test_reset_mid_pulse();
      reset = 1'b1;
      tick();
      reset          = 1'b0;
      bus.cpu_seq_en = 1'b1;
      bus.fpu_seq_en = 1'b0;
      tick();
      cpu_trigger(6'b010001, 32'h300);
      tick();  // second cycle of the pulse
      checks++;
      if (obs !== 5'b10100) begin
         errors++;
         $display("FAIL rst_mid_pre: got %b expected %b", obs, 5'b10100);
      end
      #3 reset = 1'b1;
      #1;
      checks++;
      if (obs !== 5'b00000 || bus.epc !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_async: got %b epc %h expected %b epc %h", obs, bus.epc, 5'b00000, 32'h0);
      end
      tick();
      reset = 1'b0;
      tick();
      cpu_trigger(6'b010001, 32'h340);
      checks++;
      if (obs !== 5'b10100 || bus.epc !== 32'h340) begin
         errors++;
         $display("FAIL rst_fresh_pulse1: got %b epc %h expected %b epc %h", obs, bus.epc, 5'b10100, 32'h340);
      end
      tick();
      checks++;
      if (obs !== 5'b10100) begin
         errors++;
         $display("FAIL rst_fresh_pulse2: got %b expected %b", obs, 5'b10100);
      end
      tick();
      checks++;
      if (obs !== 5'b00100) begin
         errors++;
         $display("FAIL rst_fresh_wait: got %b expected %b", obs, 5'b00100);
      end
      bus.fpu_seq_en = 1'b1;
      bus.cpu_seq_en = 1'b0;
      tick();
      checks++;
      if (obs !== 5'b00010) begin
         errors++;
         $display("FAIL rst_fresh_ack: got %b expected %b", obs, 5'b00010);
      end
   endtask

   task automatic test_early_ack();
      // Levels already confirm a switch back to the CPU before the request starts.
      bus.cpu_seq_en = 1'b1;
      bus.fpu_seq_en = 1'b0;
      fpu_trigger(32'h500);
      checks++;
      if (obs !== 5'b01110 || bus.epc !== 32'h500) begin
         errors++;
         $display("FAIL early_req1: got %b epc %h expected %b epc %h", obs, bus.epc, 5'b01110, 32'h500);
      end
      tick();
      checks++;
      if (obs !== 5'b01110) begin
         errors++;
         $display("FAIL early_req2: got %b expected %b", obs, 5'b01110);
      end
      tick();
      checks++;
      if (obs !== 5'b00110) begin
         errors++;
         $display("FAIL early_wait1: got %b expected %b", obs, 5'b00110);
      end
      tick();
      checks++;
      if (obs !== 5'b00000) begin
         errors++;
         $display("FAIL early_done: got %b expected %b", obs, 5'b00000);
      end
   endtask

   initial begin
      test_reset();
      test_cpu_to_fpu();
      test_fpu_to_cpu();
      test_ignored_triggers();
      test_timeout_err();
      test_reset_mid_pulse();
      test_early_ack();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
